card_shoe: RTL and testbench
============================

Name: card_shoe

Overview:
- Upstream card source for the blackjack datapath. It replaces the manual card-switch entry with a 52-card shoe that deals without repeats.
- On a one-cycle draw request it picks a pseudo-random undealt card and presents the rank on card_out (1..13, the same encoding the datapath card input takes), with a one-cycle card_valid strobe.
- It tracks dealt cards and the remaining count, and supports explicit and automatic reshuffle.

Parameters:
- SEED, 6'd1: LFSR reset value. A value of 0 is forced to 1.
- DECK_SIZE, 52: number of cards. Fixed at 4 suits x 13 ranks; other values are unsupported.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- draw, input, 1: request one card. Sampled only in IDLE.
- shuffle, input, 1: return all cards to the shoe.
- card_out, output, 4: rank of the dealt card. 1=A, 11=J, 12=Q, 13=K.
- suit_out, output, 2: suit of the dealt card, 0..3.
- card_valid, output, 1: one-cycle strobe; card_out and suit_out are valid while it is high.
- busy, output, 1: high in SEARCH, CLEAR and DELIVER.
- cards_left, output, 6: undealt cards, 0..52.
- shoe_empty, output, 1: equals (cards_left==0).
- reshuffled, output, 1: one-cycle pulse when CLEAR completes.

Behaviour:
- Reset values:
  - state=IDLE, used mask=0, cards_left=52, lfsr=SEED.
  - card_out=0, suit_out=0, card_valid=0, busy=0, shoe_empty=0, reshuffled=0.
- LFSR:
  - 6-bit, x^6+x^5+1; next = {lfsr[4:0], lfsr[5]^lfsr[4]}.
  - Advances every clock in every state, except on reset, so human-timed draws add entropy.
  - Period 63; it never reaches 0.
- Candidate index: idx = lfsr-1, range 0..62.
  - A hit requires idx<52 and used[idx]==0.
  - rank = (idx mod 13)+1; suit = idx/13.
- States:
  - IDLE, then in priority order:
    - shuffle: go to CLEAR.
    - draw with cards_left==0: go to CLEAR, with a draw-pending flag set.
    - draw: go to SEARCH.
    - otherwise stay in IDLE.
  - SEARCH: evaluate the current lfsr each cycle.
    - On a hit: register card_out/suit_out, set used[idx], decrement cards_left (all on the same edge), then go to DELIVER.
    - On a miss: stay in SEARCH.
    - Because of the 63-cycle LFSR sweep, a hit is guaranteed within 63 SEARCH cycles whenever cards_left>0.
  - DELIVER: card_valid=1 for exactly this cycle, then go to IDLE.
  - CLEAR: one cycle. Set used=0, cards_left=52, reshuffled=1.
    - Next state is SEARCH if draw-pending (then clear the flag), else IDLE.
- Latency, with draw sampled in IDLE at edge T:
  - SEARCH begins at T+1.
  - A hit evaluated in cycle H gives card_valid during cycle H+1.
  - Minimum latency is 2 cycles; maximum is 64 cycles, plus 1 if an auto-reshuffle occurs.
- card_out and suit_out hold the last dealt card until the next hit. Reset or shuffle does not clear them, apart from reset's own 0.
- Draw handling:
  - draw asserted outside IDLE is ignored and not queued.
  - A level-held draw in IDLE triggers a new draw each time IDLE is re-entered. The upstream control supplies single-cycle pulses.
- Simultaneous draw and shuffle in IDLE: shuffle wins and the draw is dropped. No card is dealt and draw-pending stays 0.
- shuffle during SEARCH: abort the search and go to CLEAR. No card_valid is produced and the mask is not modified by the aborted search.
  - shuffle during DELIVER or CLEAR is ignored.
- reset mid-SEARCH: all reset values apply on the next edge and no card_valid is produced.
- cards_left never underflows. The decrement happens only on a hit, and hits are impossible when it is 0.

Test Plan:
- Reset, then 52 draw pulses, each waiting for card_valid:
  - 52 distinct (card_out, suit_out) pairs; each rank 1..13 appears exactly 4 times and each suit exactly 13 times.
  - cards_left steps 51..0; shoe_empty=1 after the 52nd card.
  - Every card arrives within 64 cycles of its draw.
- 53rd draw with the shoe empty:
  - reshuffled pulses once, then card_valid.
  - cards_left=51, shoe_empty=0, dealt card is in 1..13.
- Deal 10 cards, then pulse shuffle in IDLE:
  - reshuffled pulses 1 cycle later and cards_left=52.
  - The next 52 draws are again all distinct.
- Draw and shuffle in the same cycle:
  - No card_valid within 70 cycles.
  - cards_left=52, reshuffled pulses once.
- Draw, then shuffle on the first SEARCH cycle: no card_valid, cards_left=52. Then draw and reset on the second SEARCH cycle: no card_valid, cards_left=52, busy=0 after the reset edge.
- Draw held high for 3 cycles in IDLE: exactly one card_valid from that window. Draws held during busy are not counted; cards_left drops by 1 per card_valid.

Source files
------------

// File: rtl/card_shoe.sv
// card_shoe: 52-card shoe dealing pseudo-random undealt cards without repeats.
// A free-running 6-bit LFSR sweeps candidate indices; a used mask rejects repeats.
module card_shoe #(
  parameter logic [5:0] SEED      = 6'd1,
  parameter int         DECK_SIZE = 52
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       draw,
  input  logic       shuffle,
  output logic [3:0] card_out,
  output logic [1:0] suit_out,
  output logic       card_valid,
  output logic       busy,
  output logic [5:0] cards_left,
  output logic       shoe_empty,
  output logic       reshuffled
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DELIVER,
    S_CLEAR
  } state_t;

  localparam logic [5:0] L_SEED = (SEED == 6'd0) ? 6'd1 : SEED;
  localparam logic [5:0] L_DECK = 6'(DECK_SIZE);

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_lfsr;
  logic [63:0] r_used;
  logic [5:0]  r_left;
  logic        r_pend;
  logic [3:0]  r_card;
  logic [1:0]  r_suit;
  logic        r_resh;

  logic [5:0]  w_idx;
  logic        w_hit;
  logic        w_deal;
  logic        w_set_pend;
  logic [3:0]  w_rank;
  logic [1:0]  w_suit;

  assign w_idx  = r_lfsr - 6'd1;
  assign w_hit  = (w_idx < L_DECK) && !r_used[w_idx];
  assign w_rank = 4'(w_idx % 6'd13) + 4'd1;
  assign w_suit = 2'(w_idx / 6'd13);
  // An abort by shuffle takes priority over a hit in the same cycle.
  assign w_deal = (r_state == S_SEARCH) && !shuffle && w_hit;

  always_comb begin
    w_next     = r_state;
    w_set_pend = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (shuffle) begin
          w_next = S_CLEAR;
        end else if (draw) begin
          if (r_left == 6'd0) begin
            w_next     = S_CLEAR;
            w_set_pend = 1'b1;
          end else begin
            w_next = S_SEARCH;
          end
        end
      end
      S_SEARCH: begin
        if (shuffle) begin
          w_next = S_CLEAR;
        end else if (w_hit) begin
          w_next = S_DELIVER;
        end
      end
      S_DELIVER: w_next = S_IDLE;
      S_CLEAR:   w_next = r_pend ? S_SEARCH : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_lfsr  <= L_SEED;
      r_used  <= '0;
      r_left  <= L_DECK;
      r_pend  <= 1'b0;
      r_card  <= 4'd0;
      r_suit  <= 2'd0;
      r_resh  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_lfsr  <= {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};
      r_resh  <= (r_state == S_CLEAR);
      if (r_state == S_CLEAR) begin
        r_used <= '0;
        r_left <= L_DECK;
        r_pend <= 1'b0;
      end else begin
        if (w_set_pend) begin
          r_pend <= 1'b1;
        end
        if (w_deal) begin
          r_used[w_idx] <= 1'b1;
          r_left        <= r_left - 6'd1;
          r_card        <= w_rank;
          r_suit        <= w_suit;
        end
      end
    end
  end

  assign card_out   = r_card;
  assign suit_out   = r_suit;
  assign card_valid = (r_state == S_DELIVER);
  assign busy       = (r_state != S_IDLE);
  assign cards_left = r_left;
  assign shoe_empty = (r_left == 6'd0);
  assign reshuffled = r_resh;

endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: randomized-timing bench for card_shoe.
// Reference predicts each dealt card from the LFSR sweep rule and a dealt-card set.
`timescale 1ns/1ps
module tb_card_shoe;

  localparam logic [5:0] TB_SEED = 6'd1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       draw = 1'b0;
  logic       shuffle = 1'b0;
  logic [3:0] card_out;
  logic [1:0] suit_out;
  logic       card_valid;
  logic       busy;
  logic [5:0] cards_left;
  logic       shoe_empty;
  logic       reshuffled;

  card_shoe #(.SEED(TB_SEED), .DECK_SIZE(52)) dut (
    .clk        (clk),
    .reset      (reset),
    .draw       (draw),
    .shuffle    (shuffle),
    .card_out   (card_out),
    .suit_out   (suit_out),
    .card_valid (card_valid),
    .busy       (busy),
    .cards_left (cards_left),
    .shoe_empty (shoe_empty),
    .reshuffled (reshuffled)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // reference state: LFSR position, dealt set, remaining count
  logic [5:0] m_lfsr;
  bit [51:0]  m_used;
  int         m_left;
  int         rank_cnt[14];
  int         suit_cnt[4];
  logic [3:0] c_card;
  logic [1:0] c_suit;

  function automatic logic [5:0] nxt(input logic [5:0] v);
    return {v[4:0], v[5] ^ v[4]};
  endfunction

  always @(posedge clk) begin
    if (reset) m_lfsr <= TB_SEED;
    else       m_lfsr <= nxt(m_lfsr);
  end

  // number of misses before the first undealt card, starting from value start
  function automatic int find_hit(input logic [5:0] start, output int idx);
    logic [5:0] v;
    v = start;
    idx = -1;
    for (int k = 0; k < 63; k++) begin
      int i;
      i = int'(v) - 1;
      if (i < 52 && !m_used[i]) begin
        idx = i;
        return k;
      end
      v = nxt(v);
    end
    return -1;
  endfunction

  task automatic wait_valid(input int budget, input bit stop,
                            output int lat, output int rs, output int nv);
    lat = -1;
    rs = 0;
    nv = 0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      #1;
      if (reshuffled) rs++;
      if (card_valid) begin
        nv++;
        if (lat < 0) begin
          lat = n;
          c_card = card_out;
          c_suit = suit_out;
        end
      end
      if (stop && lat >= 0) break;
    end
  endtask

  task automatic model_clear();
    m_used = '0;
    m_left = 52;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    draw = 1'b0;
    shuffle = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    n_checks++;
    if (cards_left !== 6'd52) begin
      n_fail++;
      $display("FAIL reset_left: got %0d want 52", cards_left);
    end
    n_checks++;
    if ({card_out, suit_out} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_card: got %0d/%0d want 0/0", card_out, suit_out);
    end
    n_checks++;
    if ({card_valid, busy, shoe_empty, reshuffled} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got v%b b%b e%b r%b want 0",
               card_valid, busy, shoe_empty, reshuffled);
    end
  endtask

  task automatic test_single_draw(input bit auto_rs);
    logic [5:0] start;
    int k, idx, lat, rs, nv, oi;
    bit dup;
    draw = 1'b1;
    @(posedge clk);
    #1;
    draw = 1'b0;
    if (auto_rs) begin
      model_clear();
      start = nxt(m_lfsr);
    end else begin
      start = m_lfsr;
    end
    k = find_hit(start, idx);
    wait_valid(70, 1'b1, lat, rs, nv);
    n_checks++;
    if (lat !== k + 1 + int'(auto_rs)) begin
      n_fail++;
      $display("FAIL draw_latency: got %0d want %0d", lat, k + 1 + int'(auto_rs));
    end
    n_checks++;
    if (lat < 1 || lat > 63 + int'(auto_rs)) begin
      n_fail++;
      $display("FAIL draw_bound: got %0d want 1..%0d", lat, 63 + int'(auto_rs));
    end
    n_checks++;
    if (c_card !== 4'(idx % 13 + 1) || c_suit !== 2'(idx / 13)) begin
      n_fail++;
      $display("FAIL draw_card: got %0d/%0d want %0d/%0d",
               c_card, c_suit, idx % 13 + 1, idx / 13);
    end
    n_checks++;
    if (rs !== int'(auto_rs)) begin
      n_fail++;
      $display("FAIL draw_reshuffled: got %0d pulses want %0d", rs, int'(auto_rs));
    end
    oi = int'(c_card) - 1 + 13 * int'(c_suit);
    dup = (c_card < 4'd1 || c_card > 4'd13) ? 1'b1 : m_used[oi];
    n_checks++;
    if (dup) begin
      n_fail++;
      $display("FAIL draw_repeat: got %0d/%0d want undealt 1..13", c_card, c_suit);
    end
    if (idx >= 0) begin
      m_used[idx] = 1'b1;
      m_left--;
    end
    if (c_card >= 4'd1 && c_card <= 4'd13) begin
      rank_cnt[c_card]++;
      suit_cnt[c_suit]++;
    end
    n_checks++;
    if (cards_left !== 6'(m_left) || shoe_empty !== (m_left == 0)) begin
      n_fail++;
      $display("FAIL draw_left: got %0d e%b want %0d e%b",
               cards_left, shoe_empty, m_left, m_left == 0);
    end
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1;
  endtask

  task automatic test_full_deck();
    for (int r = 0; r < 14; r++) rank_cnt[r] = 0;
    for (int s = 0; s < 4; s++) suit_cnt[s] = 0;
    for (int i = 0; i < 52; i++) test_single_draw(1'b0);
    for (int r = 1; r <= 13; r++) begin
      n_checks++;
      if (rank_cnt[r] !== 4) begin
        n_fail++;
        $display("FAIL deck_rank: rank %0d got %0d want 4", r, rank_cnt[r]);
      end
    end
    for (int s = 0; s < 4; s++) begin
      n_checks++;
      if (suit_cnt[s] !== 13) begin
        n_fail++;
        $display("FAIL deck_suit: suit %0d got %0d want 13", s, suit_cnt[s]);
      end
    end
    n_checks++;
    if (shoe_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL deck_empty: got %b want 1", shoe_empty);
    end
  endtask

  task automatic test_auto_reshuffle();
    test_single_draw(1'b1);
    n_checks++;
    if (cards_left !== 6'd51 || shoe_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_left: got %0d e%b want 51 e0", cards_left, shoe_empty);
    end
  endtask

  task automatic test_shuffle();
    int lat, rs, nv;
    for (int i = 0; i < 10; i++) test_single_draw(1'b0);
    shuffle = 1'b1;
    @(posedge clk);
    #1;
    shuffle = 1'b0;
    wait_valid(3, 1'b0, lat, rs, nv);
    n_checks++;
    if (rs !== 1 || nv !== 0) begin
      n_fail++;
      $display("FAIL shuffle_pulse: got %0d pulses %0d valids want 1/0", rs, nv);
    end
    n_checks++;
    if (cards_left !== 6'd52) begin
      n_fail++;
      $display("FAIL shuffle_left: got %0d want 52", cards_left);
    end
    model_clear();
    for (int i = 0; i < 52; i++) test_single_draw(1'b0);
  endtask

  task automatic test_draw_shuffle();
    int lat, rs, nv;
    draw = 1'b1;
    shuffle = 1'b1;
    @(posedge clk);
    #1;
    draw = 1'b0;
    shuffle = 1'b0;
    wait_valid(70, 1'b0, lat, rs, nv);
    model_clear();
    n_checks++;
    if (nv !== 0 || rs !== 1) begin
      n_fail++;
      $display("FAIL both_pulses: got %0d valids %0d reshuffles want 0/1", nv, rs);
    end
    n_checks++;
    if (cards_left !== 6'd52 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL both_left: got %0d b%b want 52 b0", cards_left, busy);
    end
  endtask

  task automatic test_abort();
    int lat, rs, nv, k, idx;
    draw = 1'b1;
    @(posedge clk);
    #1;
    draw = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy: got %b want 1", busy);
    end
    shuffle = 1'b1;
    @(posedge clk);
    #1;
    shuffle = 1'b0;
    wait_valid(70, 1'b0, lat, rs, nv);
    model_clear();
    n_checks++;
    if (nv !== 0 || rs !== 1 || cards_left !== 6'd52) begin
      n_fail++;
      $display("FAIL abort_shuffle: got %0d valids %0d reshuffles left %0d want 0/1/52",
               nv, rs, cards_left);
    end
    // pick a draw moment whose search needs at least two misses
    for (int n = 0; n < 200; n++) begin
      k = find_hit(nxt(m_lfsr), idx);
      if (k >= 2) break;
      @(posedge clk);
      #1;
    end
    draw = 1'b1;
    @(posedge clk);
    #1;
    draw = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || card_valid !== 1'b0 || cards_left !== 6'd52 || card_out !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset_state: got b%b v%b left %0d card %0d want b0 v0 52 0",
               busy, card_valid, cards_left, card_out);
    end
    wait_valid(70, 1'b0, lat, rs, nv);
    n_checks++;
    if (nv !== 0) begin
      n_fail++;
      $display("FAIL midreset_valid: got %0d valids want 0", nv);
    end
  endtask

  task automatic test_held_draw();
    int k, idx, lat, nv;
    logic [5:0] start;
    lat = -1;
    nv = 0;
    draw = 1'b1;
    @(posedge clk);
    #1;
    start = m_lfsr;
    k = find_hit(start, idx);
    for (int n = 1; n <= 70; n++) begin
      @(posedge clk);
      #1;
      if (n == 2) draw = 1'b0;
      if (card_valid) begin
        nv++;
        if (lat < 0) begin
          lat = n;
          c_card = card_out;
          c_suit = suit_out;
        end
      end
    end
    draw = 1'b0;
    if (idx >= 0) begin
      m_used[idx] = 1'b1;
      m_left--;
    end
    n_checks++;
    if (nv !== 1 || lat !== k + 1) begin
      n_fail++;
      $display("FAIL held_count: got %0d valids lat %0d want 1 lat %0d", nv, lat, k + 1);
    end
    n_checks++;
    if (c_card !== 4'(idx % 13 + 1) || c_suit !== 2'(idx / 13)) begin
      n_fail++;
      $display("FAIL held_card: got %0d/%0d want %0d/%0d",
               c_card, c_suit, idx % 13 + 1, idx / 13);
    end
    n_checks++;
    if (cards_left !== 6'(m_left)) begin
      n_fail++;
      $display("FAIL held_left: got %0d want %0d", cards_left, m_left);
    end
  endtask

  initial begin
    test_reset();
    test_full_deck();
    test_auto_reshuffle();
    test_shuffle();
    test_draw_shuffle();
    test_abort();
    test_held_draw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
